// File: rtl/pc_stack_pkg.sv
// rtl/pc_stack_pkg.sv - command encoding and sizing helpers for pc_stack_reg
// Shared by pc_stack_reg and lifo_stack.
package pc_stack_pkg;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_LOAD,
      CMD_CALL,
      CMD_RET,
      CMD_INC,
      CMD_DEC,
      CMD_CLR
   } cmd_t;

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic cmd_t pc_prio(input logic load, input logic call, input logic ret,
                                    input logic inc, input logic dec, input logic clr);
      if (load)      return CMD_LOAD;
      else if (call) return CMD_CALL;
      else if (ret)  return CMD_RET;
      else if (inc)  return CMD_INC;
      else if (dec)  return CMD_DEC;
      else if (clr)  return CMD_CLR;
      else           return CMD_NONE;
   endfunction

endpackage

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - return-address LIFO with occupancy count and full/empty status
// Only the count is reset; entry contents are left as they were.
module lifo_stack
   import pc_stack_pkg::*;
#(
   parameter int WIDTH = 19,
   parameter int DEPTH = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [WIDTH-1:0]             i_data,
   output logic [WIDTH-1:0]             o_top,
   output logic [cnt_width(DEPTH)-1:0]  o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int CW = cnt_width(DEPTH);
   localparam int AW = addr_width(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_top_idx;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign w_wr_idx  = AW'(r_count);
   assign w_top_idx = AW'(r_count - CW'(1));
   assign o_top     = r_mem[w_top_idx];
   assign o_count   = r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (w_do_push) begin
         r_mem[w_wr_idx] <= i_data;
         r_count         <= r_count + CW'(1);
      end else if (w_do_pop) begin
         r_count <= r_count - CW'(1);
      end
   end

endmodule

// File: rtl/pc_stack_reg.sv
// rtl/pc_stack_reg.sv - program counter with LOAD/CALL/RET/INC/CLR and return-address stack
// Defining PC_STACK_DEC_EN adds the DEC port and decrement operation.
module pc_stack_reg
   import pc_stack_pkg::*;
#(
   parameter int               WIDTH       = 19,
   parameter int               STACK_DEPTH = 8,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic [WIDTH-1:0]                   inpData,
   input  logic                               LOAD,
   input  logic                               CALL,
   input  logic                               RET,
   input  logic                               INC,
`ifdef PC_STACK_DEC_EN
   input  logic                               DEC,
`endif
   input  logic                               CLR,
   output logic [WIDTH-1:0]                   opData,
   output logic                               STK_FULL,
   output logic                               STK_EMPTY,
   output logic                               STK_ERR,
   output logic [cnt_width(STACK_DEPTH)-1:0]  STK_CNT
);

   logic [WIDTH-1:0] r_pc;
   logic             r_err;
   logic [WIDTH-1:0] w_top;
   logic             w_dec;
   logic             w_full;
   logic             w_empty;
   cmd_t             w_cmd;

`ifdef PC_STACK_DEC_EN
   assign w_dec = DEC;
`else
   assign w_dec = 1'b0;
`endif

   assign w_cmd = pc_prio(LOAD, CALL, RET, INC, w_dec, CLR);

   // Return address is the instruction after the call site, wrapping like INC.
   lifo_stack #(
      .WIDTH (WIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_push  (w_cmd == CMD_CALL),
      .i_pop   (w_cmd == CMD_RET),
      .i_data  (r_pc + WIDTH'(1)),
      .o_top   (w_top),
      .o_count (STK_CNT),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pc  <= RESET_VAL;
         r_err <= 1'b0;
      end else begin
         case (w_cmd)
            CMD_LOAD: r_pc <= inpData;
            CMD_CALL: begin
               if (w_full) r_err <= 1'b1;
               else        r_pc  <= inpData;
            end
            CMD_RET: begin
               if (w_empty) r_err <= 1'b1;
               else         r_pc  <= w_top;
            end
            CMD_INC:  r_pc <= r_pc + WIDTH'(1);
`ifdef PC_STACK_DEC_EN
            CMD_DEC:  r_pc <= r_pc - WIDTH'(1);
`endif
            CMD_CLR: begin
               r_pc  <= '0;
               r_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign opData    = r_pc;
   assign STK_ERR   = r_err;
   assign STK_FULL  = w_full;
   assign STK_EMPTY = w_empty;

endmodule

// File: tb/tb_pc_stack_reg.sv
// tb/tb_pc_stack_reg.sv - directed self-checking bench for pc_stack_reg
// Covers the DEC path too when PC_STACK_DEC_EN is defined.
module tb_pc_stack_reg;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [18:0] inpData = '0;
   logic        LOAD = 1'b0, CALL = 1'b0, RET = 1'b0, INC = 1'b0, CLR = 1'b0;
   logic        DEC = 1'b0;
   logic [18:0] opData;
   logic        STK_FULL, STK_EMPTY, STK_ERR;
   logic [3:0]  STK_CNT;

   int total = 0;
   int bad   = 0;

   pc_stack_reg #(.WIDTH(19), .STACK_DEPTH(8), .RESET_VAL(19'h0)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .inpData   (inpData),
      .LOAD      (LOAD),
      .CALL      (CALL),
      .RET       (RET),
      .INC       (INC),
`ifdef PC_STACK_DEC_EN
      .DEC       (DEC),
`endif
      .CLR       (CLR),
      .opData    (opData),
      .STK_FULL  (STK_FULL),
      .STK_EMPTY (STK_EMPTY),
      .STK_ERR   (STK_ERR),
      .STK_CNT   (STK_CNT)
   );

   always #5 CLK = ~CLK;

   // Apply one set of controls for exactly one rising edge, then release them.
   task automatic cycle(input logic rst, input logic ld, input logic cl, input logic rt,
                        input logic in, input logic dc, input logic cr, input logic [18:0] d);
      RST = rst; LOAD = ld; CALL = cl; RET = rt; INC = in; DEC = dc; CLR = cr; inpData = d;
      @(posedge CLK);
      #1;
      RST = 0; LOAD = 0; CALL = 0; RET = 0; INC = 0; DEC = 0; CLR = 0;
   endtask

   task automatic test_reset;
      cycle(1, 0, 0, 0, 0, 0, 0, 19'h0);
      total++; if (opData !== 19'h0) begin bad++; $display("FAIL reset_op got=%h exp=00000", opData); end
      total++; if (STK_EMPTY !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", STK_EMPTY); end
      total++; if (STK_FULL !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", STK_FULL); end
      total++; if (STK_ERR !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", STK_ERR); end
      total++; if (STK_CNT !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", STK_CNT); end
   endtask

   task automatic test_load_inc;
      cycle(0, 1, 0, 0, 0, 0, 0, 19'h7FFFE);
      total++; if (opData !== 19'h7FFFE) begin bad++; $display("FAIL load got=%h exp=7fffe", opData); end
      cycle(0, 0, 0, 0, 1, 0, 0, 19'h0);
      total++; if (opData !== 19'h7FFFF) begin bad++; $display("FAIL inc1 got=%h exp=7ffff", opData); end
      cycle(0, 0, 0, 0, 1, 0, 0, 19'h0);
      total++; if (opData !== 19'h00000) begin bad++; $display("FAIL inc_wrap got=%h exp=00000", opData); end
   endtask

   task automatic test_call_ret;
      cycle(0, 1, 0, 0, 0, 0, 0, 19'h10);
      cycle(0, 0, 1, 0, 0, 0, 0, 19'h200);
      total++; if (opData !== 19'h200) begin bad++; $display("FAIL call_op got=%h exp=00200", opData); end
      total++; if (STK_CNT !== 4'd1) begin bad++; $display("FAIL call_cnt got=%0d exp=1", STK_CNT); end
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0, 0, 19'h0);
      total++; if (opData !== 19'h203) begin bad++; $display("FAIL sub_inc got=%h exp=00203", opData); end
      cycle(0, 0, 0, 1, 0, 0, 0, 19'h0);
      total++; if (opData !== 19'h11) begin bad++; $display("FAIL ret_op got=%h exp=00011", opData); end
      total++; if (STK_EMPTY !== 1'b1) begin bad++; $display("FAIL ret_empty got=%b exp=1", STK_EMPTY); end
   endtask

   // Stack after 8 calls from opData=0x11: 0x12, 0x101..0x107 (bottom to top).
   task automatic test_overflow;
      logic [18:0] exp;
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0, 0, 0, 19'h100 + 19'(i));
      total++; if (STK_FULL !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", STK_FULL); end
      total++; if (opData !== 19'h107) begin bad++; $display("FAIL ovf_op8 got=%h exp=00107", opData); end
      cycle(0, 0, 1, 0, 0, 0, 0, 19'h55);
      total++; if (opData !== 19'h107) begin bad++; $display("FAIL ovf_hold got=%h exp=00107", opData); end
      total++; if (STK_CNT !== 4'd8) begin bad++; $display("FAIL ovf_cnt got=%0d exp=8", STK_CNT); end
      total++; if (STK_ERR !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", STK_ERR); end
      cycle(0, 0, 0, 0, 0, 0, 1, 19'h0);
      total++; if (opData !== 19'h0) begin bad++; $display("FAIL clr_op got=%h exp=00000", opData); end
      total++; if (STK_ERR !== 1'b0) begin bad++; $display("FAIL clr_err got=%b exp=0", STK_ERR); end
      total++; if (STK_CNT !== 4'd8) begin bad++; $display("FAIL clr_cnt got=%0d exp=8", STK_CNT); end
      for (int k = 0; k < 8; k++) begin
         exp = (k < 7) ? (19'h107 - 19'(k)) : 19'h12;
         cycle(0, 0, 0, 1, 0, 0, 0, 19'h0);
         total++; if (opData !== exp) begin bad++; $display("FAIL pop%0d got=%h exp=%h", k, opData, exp); end
      end
      total++; if (STK_EMPTY !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", STK_EMPTY); end
   endtask

   task automatic test_underflow_priority;
      cycle(0, 0, 0, 1, 0, 0, 0, 19'h0);
      total++; if (STK_ERR !== 1'b1) begin bad++; $display("FAIL udf_err got=%b exp=1", STK_ERR); end
      total++; if (opData !== 19'h12) begin bad++; $display("FAIL udf_hold got=%h exp=00012", opData); end
      cycle(0, 1, 1, 0, 1, 0, 0, 19'h3);
      total++; if (opData !== 19'h3) begin bad++; $display("FAIL prio_load got=%h exp=00003", opData); end
      total++; if (STK_CNT !== 4'd0) begin bad++; $display("FAIL prio_cnt got=%0d exp=0", STK_CNT); end
      total++; if (STK_ERR !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", STK_ERR); end
      cycle(0, 0, 1, 1, 1, 0, 1, 19'h40);
      total++; if (opData !== 19'h40) begin bad++; $display("FAIL prio_call got=%h exp=00040", opData); end
      total++; if (STK_CNT !== 4'd1) begin bad++; $display("FAIL prio_call_cnt got=%0d exp=1", STK_CNT); end
      cycle(0, 0, 0, 0, 1, 0, 1, 19'h0);
      total++; if (opData !== 19'h41) begin bad++; $display("FAIL prio_inc got=%h exp=00041", opData); end
      total++; if (STK_ERR !== 1'b1) begin bad++; $display("FAIL inc_over_clr_err got=%b exp=1", STK_ERR); end
      cycle(0, 0, 0, 1, 1, 0, 0, 19'h0);
      total++; if (opData !== 19'h4) begin bad++; $display("FAIL prio_ret got=%h exp=00004", opData); end
   endtask

   task automatic test_push_wrap;
      cycle(0, 1, 0, 0, 0, 0, 0, 19'h7FFFF);
      cycle(0, 0, 1, 0, 0, 0, 0, 19'h5);
      cycle(0, 0, 0, 1, 0, 0, 0, 19'h0);
      total++; if (opData !== 19'h0) begin bad++; $display("FAIL push_wrap got=%h exp=00000", opData); end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0, 0, 19'h300 + 19'(i));
      total++; if (STK_CNT !== 4'd3) begin bad++; $display("FAIL pre_rst_cnt got=%0d exp=3", STK_CNT); end
      cycle(1, 0, 1, 0, 0, 0, 0, 19'h77);
      total++; if (opData !== 19'h0) begin bad++; $display("FAIL rst_mid_op got=%h exp=00000", opData); end
      total++; if (STK_CNT !== 4'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", STK_CNT); end
      total++; if (STK_EMPTY !== 1'b1) begin bad++; $display("FAIL rst_mid_empty got=%b exp=1", STK_EMPTY); end
      cycle(0, 0, 0, 1, 0, 0, 0, 19'h0);
      total++; if (STK_ERR !== 1'b1) begin bad++; $display("FAIL rst_mid_udf got=%b exp=1", STK_ERR); end
      total++; if (opData !== 19'h0) begin bad++; $display("FAIL rst_mid_hold got=%h exp=00000", opData); end
   endtask

`ifdef PC_STACK_DEC_EN
   task automatic test_dec;
      cycle(1, 0, 0, 0, 0, 0, 0, 19'h0);
      cycle(0, 0, 0, 0, 0, 1, 0, 19'h0);
      total++; if (opData !== 19'h7FFFF) begin bad++; $display("FAIL dec_wrap got=%h exp=7ffff", opData); end
      cycle(0, 0, 0, 0, 1, 1, 0, 19'h0);
      total++; if (opData !== 19'h0) begin bad++; $display("FAIL inc_over_dec got=%h exp=00000", opData); end
      cycle(0, 1, 0, 0, 0, 0, 0, 19'h20);
      cycle(0, 0, 0, 0, 0, 1, 1, 19'h0);
      total++; if (opData !== 19'h1F) begin bad++; $display("FAIL dec_over_clr got=%h exp=0001f", opData); end
   endtask
`endif

   initial begin
      #2;
      test_reset;
      test_load_inc;
      test_call_ret;
      test_overflow;
      test_underflow_priority;
      test_push_wrap;
      test_reset_mid;
`ifdef PC_STACK_DEC_EN
      test_dec;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_stack_reg.md
Name: pc_stack_reg

Overview:
Parametrised successor to the 19-bit load/increment/clear register, used as the CPU program counter. It keeps the LOAD/INC/CLR operations and adds subroutine CALL/RET. These are backed by an internal LIFO return-address stack with full/empty status and a sticky error flag. It sits between the control unit, which supplies the commands, and the instruction-memory address bus, which it drives from opData.

Parameters:
WIDTH, 19, register and return-address width in bits (>=2)
STACK_DEPTH, 8, number of return-address entries (>=1)
RESET_VAL, 0, value loaded into opData on RST (WIDTH bits)

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  synchronous, active-high reset
inpData  input  WIDTH  load value / call target
LOAD  input  1  load inpData
CALL  input  1  push return address, jump to inpData
RET  input  1  pop return address into opData
INC  input  1  increment opData
CLR  input  1  clear opData to 0
opData  output  WIDTH  current register value (registered)
STK_FULL  output  1  stack holds STACK_DEPTH entries
STK_EMPTY  output  1  stack holds 0 entries
STK_ERR  output  1  sticky: overflow or underflow occurred
STK_CNT  output  $clog2(STACK_DEPTH+1)  current stack occupancy

Behaviour:
- Reset is synchronous and active-high on CLK: RST=1 at posedge forces opData=RESET_VAL, STK_CNT=0, STK_EMPTY=1, STK_FULL=0, STK_ERR=0. RST overrides every command, including mid-CALL/RET. Stack contents are don't-care after reset.
- Power-up value before the first RST is unspecified; the system must assert RST.
- Command priority at each posedge (RST=0): LOAD > CALL > RET > INC > CLR > hold. Exactly one operation executes per cycle; lower-priority requests in that cycle are ignored.
- LOAD: opData <= inpData. Stack unchanged.
- CALL, not full: stack[STK_CNT] <= opData+1 (mod 2^WIDTH); STK_CNT++; opData <= inpData.
- CALL, full: no push; opData unchanged; STK_ERR <= 1.
- RET, not empty: opData <= stack[STK_CNT-1]; STK_CNT--.
- RET, empty: opData unchanged; STK_ERR <= 1.
- INC: opData <= opData+1, wrapping from all-ones to 0 with no flag.
- CLR: opData <= 0; also clears STK_ERR. Stack unchanged.
- Latency: all results are visible on opData and flags one cycle after the sampling edge. There is no combinational path from inputs to outputs.
- STK_FULL = (STK_CNT==STACK_DEPTH); STK_EMPTY = (STK_CNT==0). Both are decoded from the registered count.
- Return addresses are WIDTH-bit unsigned; the +1 wrap applies equally to pushed addresses.
- STK_ERR stays set until RST or CLR.

Optional Feature:
- Macro: PC_STACK_DEC_EN.
- Defined: adds input port DEC (1 bit). Priority becomes LOAD > CALL > RET > INC > DEC > CLR. DEC does opData <= opData-1, wrapping from 0 to all-ones. INC and DEC asserted together execute INC.
- Undefined: no DEC port, and the logic is absent.

Decomposition:
- Package pc_stack_pkg:
  - command-select enum (CMD_NONE, CMD_LOAD, CMD_CALL, CMD_RET, CMD_INC, CMD_DEC, CMD_CLR)
  - priority-encode function
  - localparam helpers for count width
- Sub-module lifo_stack (WIDTH, DEPTH): push/pop/data-in/top/count/full/empty, synchronous reset of the count only.
- pc_stack_reg instantiates lifo_stack and holds the opData register plus error logic.

Test Plan:
1. Reset: RST=1 for 1 cycle with RESET_VAL=0 -> opData=0, STK_EMPTY=1, STK_FULL=0, STK_ERR=0, STK_CNT=0.
2. Load/increment: LOAD with inpData=19'h7FFFE, then INC x2 -> opData=7FFFE, 7FFFF, 00000 (wrap).
3. Call/return: opData=0x10; CALL inpData=0x200 -> opData=0x200, STK_CNT=1; INC x3 -> 0x203; RET -> opData=0x11, STK_EMPTY=1.
4. Overflow: STACK_DEPTH=8; 8 CALLs -> STK_FULL=1; 9th CALL inpData=0x55 -> opData unchanged, STK_CNT=8, STK_ERR=1; CLR -> opData=0, STK_ERR=0, STK_CNT=8.
5. Underflow and priority: RET on empty -> STK_ERR=1, opData held. LOAD+CALL+INC together with inpData=0x3 -> opData=0x3, STK_CNT unchanged.
6. Reset mid-operation: RST asserted in the same cycle as CALL with STK_CNT=3 -> opData=RESET_VAL, STK_CNT=0, no push. With PC_STACK_DEC_EN defined, DEC from 0 -> all-ones.
